// File: rtl/fc_layer_sequencer.sv
// Layer sequencer for one Fully_Connect pass: replays the feature buffer once per
// output node, inserts drain gaps, then waits for the FC result or a timeout.
module fc_layer_sequencer #(
    parameter int DATAWIDTH      = 16,
    parameter int INPUT_NODES    = 784,
    parameter int OUTPUT_NODES   = 2,
    parameter int MULT_ADD_UNITS = 16,
    parameter int DRAIN_CYCLES   = 4,
    parameter int RUN_CODE       = 11,
    parameter int IDLE_CODE      = 1,
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic                                err,
    output logic                                buf_rd_en,
    output logic [ADDR_W-1:0]                   buf_rd_addr,
    input  logic [DATAWIDTH*MULT_ADD_UNITS-1:0] buf_rd_data,
    output logic [3:0]                          fc_state,
    output logic [DATAWIDTH*MULT_ADD_UNITS-1:0] fc_input_data,
    input  logic                                fc_done,
    input  logic [DATAWIDTH*OUTPUT_NODES-1:0]   fc_output_data,
    output logic [DATAWIDTH*OUTPUT_NODES-1:0]   result,
    output logic [$clog2(OUTPUT_NODES):0]       node_idx
);

    localparam int BEATS  = INPUT_NODES / MULT_ADD_UNITS;
    localparam int NODE_W = $clog2(OUTPUT_NODES) + 1;
    localparam int DRN_W  = $clog2(DRAIN_CYCLES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [ADDR_W-1:0] LAST_BEAT  = ADDR_W'(BEATS - 1);
    localparam logic [DRN_W-1:0]  LAST_DRAIN = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [NODE_W-1:0] LAST_NODE  = NODE_W'(OUTPUT_NODES - 1);
    localparam logic [TMO_W-1:0]  LAST_WAIT  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]        RUN_ST     = 4'(RUN_CODE);
    localparam logic [3:0]        IDLE_ST    = 4'(IDLE_CODE);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        WAIT_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  beat_cnt;
    logic [DRN_W-1:0]   drain_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               accept;
    logic               fin_ok;
    logic               fin_tmo;
    logic               last_beat;
    logic               last_drain;
    logic               last_node;
    logic               last_wait;
    logic               rd_vld_p0;
    logic               first_p0;
    logic               run;

    assign last_beat  = (beat_cnt == LAST_BEAT);
    assign last_drain = (drain_cnt == LAST_DRAIN);
    assign last_node  = (node_idx == LAST_NODE);
    assign last_wait  = (tmo_cnt == LAST_WAIT);

    assign busy        = (state != IDLE);
    assign buf_rd_en   = (state == FETCH);
    assign buf_rd_addr = beat_cnt;
    assign fc_state    = run ? RUN_ST : IDLE_ST;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A start landing on the done/err pulse cycle is dropped, not queued.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fin_ok    = 1'b0;
        fin_tmo   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !done && !err) begin
                    accept    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (last_beat) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (last_drain) begin
                    state_nxt = last_node ? WAIT_DONE : FETCH;
                end
            end
            WAIT_DONE: begin
                if (fc_done) begin
                    fin_ok    = 1'b1;
                    state_nxt = IDLE;
                end else if (last_wait) begin
                    fin_tmo   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt  <= '0;
            drain_cnt <= '0;
            node_idx  <= '0;
            tmo_cnt   <= '0;
        end else begin
            if (accept) begin
                beat_cnt <= '0;
            end else if (state == FETCH) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end

            if (state == DRAIN) begin
                drain_cnt <= last_drain ? '0 : drain_cnt + 1'b1;
            end

            if (accept) begin
                node_idx <= '0;
            end else if ((state == DRAIN) && last_drain) begin
                node_idx <= node_idx + 1'b1;
            end

            tmo_cnt <= (state == WAIT_DONE) ? tmo_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            done <= fin_ok;
            err  <= fin_tmo;
            if (fin_ok) begin
                result <= fc_output_data;
            end
        end
    end

    // Stage p0: buffer answers the read issued last cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_vld_p0 <= 1'b0;
            first_p0  <= 1'b0;
        end else begin
            rd_vld_p0 <= buf_rd_en;
            first_p0  <= buf_rd_en && (node_idx == '0) && (beat_cnt == '0);
        end
    end

    // Stage p1: beat presented to the FC datapath, zero between reads
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fc_input_data <= '0;
            run           <= 1'b0;
        end else begin
            fc_input_data <= rd_vld_p0 ? buf_rd_data : '0;
            if (first_p0) begin
                run <= 1'b1;
            end else if (fin_ok || fin_tmo) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Scoreboard bench for fc_layer_sequencer: default instance plus a 4-node,
// 2-cycle-drain variant, both fed by a registered feature-buffer model.
module tb_fc_layer_sequencer;

    localparam int DW      = 16;
    localparam int MAU     = 16;
    localparam int BW      = DW * MAU;
    localparam int BEATS   = 49;
    localparam int NODES   = 2;
    localparam int DRAIN   = 4;
    localparam int TMO     = 1024;
    localparam int V_NODES = 4;
    localparam int V_DRAIN = 2;
    localparam int NOM_OFF = DRAIN - 1 + 5;

    typedef struct {
        logic [BW-1:0] data;
        int            gap;
        bit            first;
    } beat_t;

    typedef struct {
        int addr;
        int node;
    } rd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start, busy, done, err, rd_en, fc_done;
    logic [9:0]    rd_addr;
    logic [BW-1:0] rd_data, fc_in;
    logic [3:0]    fc_state;
    logic [31:0]   fc_out, result;
    logic [1:0]    node_idx;

    logic          v_start, v_busy, v_done, v_err, v_rd_en, v_fc_done;
    logic [9:0]    v_rd_addr;
    logic [BW-1:0] v_rd_data, v_fc_in;
    logic [3:0]    v_fc_state;
    logic [63:0]   v_fc_out, v_result;
    logic [2:0]    v_node_idx;

    fc_layer_sequencer u_dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
        .buf_rd_en(rd_en), .buf_rd_addr(rd_addr), .buf_rd_data(rd_data),
        .fc_state(fc_state), .fc_input_data(fc_in), .fc_done(fc_done),
        .fc_output_data(fc_out), .result(result), .node_idx(node_idx)
    );

    fc_layer_sequencer #(.OUTPUT_NODES(V_NODES), .DRAIN_CYCLES(V_DRAIN)) u_var (
        .clk(clk), .reset(reset), .start(v_start), .busy(v_busy), .done(v_done), .err(v_err),
        .buf_rd_en(v_rd_en), .buf_rd_addr(v_rd_addr), .buf_rd_data(v_rd_data),
        .fc_state(v_fc_state), .fc_input_data(v_fc_in), .fc_done(v_fc_done),
        .fc_output_data(v_fc_out), .result(v_result), .node_idx(v_node_idx)
    );

    function automatic logic [BW-1:0] word(input int k);
        return (k % 2 == 0) ? {MAU{16'h3c00}} : {MAU{16'h4000}};
    endfunction

    // Junk on idle cycles so any leak onto fc_input_data shows up as a stray beat
    always @(posedge clk) rd_data   <= rd_en   ? word(int'(rd_addr))   : {MAU{16'hbad0}};
    always @(posedge clk) v_rd_data <= v_rd_en ? word(int'(v_rd_addr)) : {MAU{16'hbad0}};

    int    n_tests = 0, n_fail = 0, cyc = 0;
    beat_t beat_q[$];
    rd_t   rd_q[$];
    int    rd_cnt, done_cnt, err_cnt, done_cyc, err_cyc, last_cyc, zero_run, st_bad;
    int    fc_mode, fc_off;
    bit    exp_run, last_seen, busy_q;
    int    v_rd_cnt, v_beats, v_zero, v_gaps, v_gap_bad, v_bad, v_steps, v_done_cnt, v_last;
    logic [2:0] v_node_q;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        beat_t b;
        rd_t   r;
        @(negedge clk);
        cyc++;
        if (rd_en) begin
            if (rd_q.size() == 0) begin
                check("rd_extra", 1, 0);
            end else begin
                r = rd_q.pop_front();
                check("rd_addr", rd_addr, r.addr);
                check("rd_node", node_idx, r.node);
            end
            rd_cnt++;
        end
        if (fc_in != '0) begin
            if (beat_q.size() == 0) begin
                check("beat_extra", 1, 0);
            end else begin
                b = beat_q.pop_front();
                check("beat_data", fc_in, b.data);
                check("beat_gap", zero_run, b.gap);
                if (b.first) exp_run = 1'b1;
                if (beat_q.size() == 0) begin
                    last_seen = 1'b1;
                    last_cyc  = cyc;
                end
            end
            zero_run = 0;
        end else if (busy && !busy_q) begin
            zero_run = 1;
        end else begin
            zero_run++;
        end
        busy_q = busy;
        if (done) begin done_cnt++; done_cyc = cyc; exp_run = 1'b0; end
        if (err)  begin err_cnt++;  err_cyc  = cyc; exp_run = 1'b0; end
        if (fc_state !== (exp_run ? 4'd11 : 4'd1)) st_bad++;
        fc_done = (fc_mode != 0) && last_seen && (cyc == last_cyc + fc_off);

        if (v_rd_en) begin
            if (int'(v_rd_addr) != v_rd_cnt % BEATS || int'(v_node_idx) != v_rd_cnt / BEATS) v_bad++;
            v_rd_cnt++;
        end
        if (v_fc_in != '0) begin
            if (v_fc_in != word(v_beats % BEATS)) v_bad++;
            if (v_beats > 0 && v_zero > 0) begin
                v_gaps++;
                if (v_zero != V_DRAIN) v_gap_bad++;
            end
            v_beats++;
            if (v_beats == V_NODES * BEATS) v_last = cyc;
            v_zero = 0;
        end else begin
            v_zero++;
        end
        if (v_node_idx != v_node_q) begin
            v_steps++;
            if (v_node_idx != v_node_q + 3'd1) v_bad++;
        end
        v_node_q = v_node_idx;
        if (v_done) v_done_cnt++;
        v_fc_done = (v_beats == V_NODES * BEATS) && (cyc == v_last + 6);
    endtask

    task automatic prepare(input int mode, input int off, input logic [31:0] outv);
        beat_t b;
        rd_t   r;
        rd_q.delete();
        beat_q.delete();
        for (int n = 0; n < NODES; n++) begin
            for (int k = 0; k < BEATS; k++) begin
                r.addr  = k;
                r.node  = n;
                b.data  = word(k);
                b.gap   = (k != 0) ? 0 : ((n == 0) ? 2 : DRAIN);
                b.first = (n == 0) && (k == 0);
                rd_q.push_back(r);
                beat_q.push_back(b);
            end
        end
        rd_cnt = 0; done_cnt = 0; err_cnt = 0; st_bad = 0;
        last_seen = 1'b0; exp_run = 1'b0;
        fc_mode = mode; fc_off = off; fc_out = outv;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget, input int poke_rd);
        int n = 0;
        bit poked = 1'b0;
        while (done_cnt + err_cnt == 0 && n < budget) begin
            if (!poked && poke_rd >= 0 && rd_cnt == poke_rd) begin
                poked = 1'b1;
                pulse_start();
            end else begin
                step();
            end
            n++;
        end
        if (done_cnt + err_cnt == 0) check({tag, "_budget"}, 0, 1);
        repeat (4) step();
    endtask

    task automatic summarize(input string tag, input int exp_done, input int exp_err,
                             input logic [31:0] exp_res);
        check({tag, "_reads"}, rd_cnt, NODES * BEATS);
        check({tag, "_rd_left"}, rd_q.size(), 0);
        check({tag, "_beats_left"}, beat_q.size(), 0);
        check({tag, "_done_cnt"}, done_cnt, exp_done);
        check({tag, "_err_cnt"}, err_cnt, exp_err);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fc_state"}, fc_state, 1);
        check({tag, "_state_window"}, st_bad, 0);
    endtask

    initial begin
        int n;
        reset = 1'b0; start = 1'b0; v_start = 1'b0;
        fc_done = 1'b0; v_fc_done = 1'b0; fc_out = '0; v_fc_out = 64'h1234_5678_9abc_def0;
        fc_mode = 0; fc_off = 0; exp_run = 1'b0; busy_q = 1'b0; zero_run = 0; last_seen = 1'b0;
        rd_cnt = 0; done_cnt = 0; err_cnt = 0; st_bad = 0; last_cyc = 0; done_cyc = 0; err_cyc = 0;
        v_rd_cnt = 0; v_beats = 0; v_zero = 0; v_gaps = 0; v_gap_bad = 0; v_bad = 0;
        v_steps = 0; v_done_cnt = 0; v_last = 0; v_node_q = '0;
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_fc_state", fc_state, 1);
        check("rst_fc_in", fc_in, 0);
        check("rst_result", result, 0);
        check("rst_node", node_idx, 0);
        reset = 1'b1;
        repeat (2) step();

        prepare(1, NOM_OFF, 32'h5a20_5a20);
        pulse_start();
        wait_end("nom", 2000, -1);
        summarize("nom", 1, 0, 32'h5a20_5a20);
        check("nom_done_lat", done_cyc - last_cyc, NOM_OFF + 1);

        prepare(0, 0, 32'h1111_2222);
        pulse_start();
        wait_end("tmo", 2000, -1);
        summarize("tmo", 0, 1, 32'h5a20_5a20);
        check("tmo_err_lat", err_cyc - last_cyc, DRAIN - 1 + TMO);

        prepare(1, NOM_OFF, 32'h5a20_5a20);
        pulse_start();
        wait_end("busy_start", 2000, BEATS + 10);
        summarize("busy_start", 1, 0, 32'h5a20_5a20);

        prepare(1, NOM_OFF, 32'h5a20_5a20);
        pulse_start();
        n = 0;
        while (rd_cnt < 20 && n < 200) begin step(); n++; end
        #2 reset = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_rd_en", rd_en, 0);
        check("arst_rd_addr", rd_addr, 0);
        check("arst_fc_state", fc_state, 1);
        check("arst_fc_in", fc_in, 0);
        check("arst_node", node_idx, 0);
        check("arst_result", result, 0);
        check("arst_done_err", {done, err}, 0);
        rd_q.delete(); beat_q.delete(); exp_run = 1'b0; done_cnt = 0; err_cnt = 0;
        repeat (2) step();
        reset = 1'b1;
        repeat (3) step();
        check("arst_no_pulse", done_cnt + err_cnt, 0);
        prepare(1, NOM_OFF, 32'h5a20_5a20);
        pulse_start();
        wait_end("rerun", 2000, -1);
        summarize("rerun", 1, 0, 32'h5a20_5a20);
        check("rerun_done_lat", done_cyc - last_cyc, NOM_OFF + 1);

        prepare(1, DRAIN - 1 + TMO - 1, 32'h3c00_4000);
        pulse_start();
        n = 0;
        while (done_cnt + err_cnt == 0 && n < 2000) begin step(); n++; end
        check("sim_done_cnt", done_cnt, 1);
        check("sim_err_cnt", err_cnt, 0);
        check("sim_result", result, 32'h3c00_4000);
        check("sim_done_lat", done_cyc - last_cyc, DRAIN - 1 + TMO);
        check("sim_state_window", st_bad, 0);
        start = 1'b1;
        step();
        check("sim_start_on_done", busy, 0);
        prepare(1, NOM_OFF, 32'h5a20_5a20);
        step();
        start = 1'b0;
        check("sim_start_next", busy, 1);
        wait_end("chain", 2000, -1);
        summarize("chain", 1, 0, 32'h5a20_5a20);

        v_start = 1'b1;
        step();
        v_start = 1'b0;
        n = 0;
        while (v_done_cnt == 0 && n < 3000) begin step(); n++; end
        repeat (4) step();
        check("var_reads", v_rd_cnt, V_NODES * BEATS);
        check("var_beats", v_beats, V_NODES * BEATS);
        check("var_gaps", v_gaps, V_NODES - 1);
        check("var_gap_len", v_gap_bad, 0);
        check("var_seq", v_bad, 0);
        check("var_node_steps", v_steps, V_NODES);
        check("var_node_final", v_node_idx, V_NODES);
        check("var_done_cnt", v_done_cnt, 1);
        check("var_result", v_result, 64'h1234_5678_9abc_def0);
        check("var_busy", v_busy, 0);
        check("var_err", v_err, 0);
        check("var_fc_state", v_fc_state, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_layer_sequencer.md
Name: fc_layer_sequencer

Overview:
- Sequences one Fully_Connect layer pass: streams the flattened feature vector from the on-chip feature buffer into the FC datapath, MULT_ADD_UNITS lanes per beat, once per output node.
- Drives the FC state code, inserts inter-node drain gaps, waits for FC done, captures the result vector and reports completion or timeout.
- Sits between the top-level layer scheduler (start/done) and the Fully_Connect instance.

Parameters:
- DATAWIDTH, 16, bits per fp16 element.
- INPUT_NODES, 784, input vector length; must be a multiple of MULT_ADD_UNITS.
- OUTPUT_NODES, 2, number of FC output neurons.
- MULT_ADD_UNITS, 16, lanes per beat. Derived BEATS = INPUT_NODES/MULT_ADD_UNITS = 49.
- DRAIN_CYCLES, 4, zero-data cycles inserted after each node's beats.
- RUN_CODE, 11, FC state code while the layer runs.
- IDLE_CODE, 1, FC state code otherwise.
- ADDR_W, 10, feature buffer address width.
- TIMEOUT_CYCLES, 1024, maximum wait for fc_done after the last drain.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to run the layer; only accepted while busy=0.
- busy  out  1  high from the cycle after start is accepted until done or err.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle timeout pulse.
- buf_rd_en  out  1  feature buffer read strobe.
- buf_rd_addr  out  ADDR_W  beat index, 0..BEATS-1.
- buf_rd_data  in  DATAWIDTH*MULT_ADD_UNITS  buffer data, valid exactly 1 cycle after buf_rd_en.
- fc_state  out  4  state code to Fully_Connect.
- fc_input_data  out  DATAWIDTH*MULT_ADD_UNITS  beat to Fully_Connect.
- fc_done  in  1  Fully_Connect completion.
- fc_output_data  in  DATAWIDTH*OUTPUT_NODES  Fully_Connect result.
- result  out  DATAWIDTH*OUTPUT_NODES  captured result.
- node_idx  out  clog2(OUTPUT_NODES)+1  output node currently being streamed.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - busy=0, done=0, err=0, buf_rd_en=0, buf_rd_addr=0.
  - fc_state=IDLE_CODE, fc_input_data=0, result=0, node_idx=0.
  - FSM goes to IDLE.
  - Reset mid-layer aborts immediately; no done or err pulse is generated.
- FSM states: IDLE, FETCH, DRAIN, WAIT_DONE.
- IDLE:
  - On start=1 at edge T: go to FETCH, set busy=1, node_idx=0, beat counter=0.
- FETCH:
  - Every cycle: buf_rd_en=1, buf_rd_addr=beat counter, beat counter increments.
  - After BEATS consecutive reads (addr 0..48), go to DRAIN.
  - No stall; the buffer contents are static for the whole layer.
- fc_input_data pipeline:
  - A register loaded with buf_rd_data on the cycle after each buf_rd_en; it is 0 on all other cycles.
  - Beat k appears on fc_input_data 2 cycles after its read was issued, for exactly 1 cycle.
  - Beats are contiguous within a node.
- DRAIN:
  - DRAIN_CYCLES cycles of fc_input_data=0 after the last beat of the node.
  - Then node_idx increments. If node_idx < OUTPUT_NODES, return to FETCH with beat counter=0. Otherwise go to WAIT_DONE.
  - For each node, the first beat follows the previous node's last beat after exactly DRAIN_CYCLES zero cycles.
- fc_state:
  - RUN_CODE from the cycle beat 0 of node 0 first appears on fc_input_data through the cycle fc_done is sampled high (or the timeout fires).
  - IDLE_CODE on the next cycle.
- WAIT_DONE:
  - Timeout counter starts at 0 on entry.
  - fc_done=1: result<=fc_output_data, done=1 for 1 cycle, busy=0, go to IDLE.
  - Counter reaches TIMEOUT_CYCLES with no fc_done: err=1 for 1 cycle, busy=0, result unchanged, go to IDLE.
  - fc_done=1 on the same cycle the timeout expires: done wins, err is not raised.
- fc_done in any state other than WAIT_DONE is ignored.
- start while busy=1 is ignored and not queued.
- start on the same cycle as the done or err pulse is ignored. A new start is accepted on the following cycle.
- result holds its value until the next successful completion or reset.
- Total cycles from start to the last non-zero beat on fc_input_data: OUTPUT_NODES*BEATS + (OUTPUT_NODES-1)*DRAIN_CYCLES + 2 = 104 at defaults.

Test Plan:
- Nominal run:
  - Stimulus: buffer word k = {16{16'h3c00}} for even k, {16{16'h4000}} for odd k; start at cycle 0; FC model asserts fc_done 5 cycles after the final drain with output 32'h5a20_5a20.
  - Required: 98 buf_rd_en pulses, addresses 0..48 twice; 4 zero cycles between nodes; fc_state=11 throughout the run; result=32'h5a20_5a20; one done pulse; busy low afterwards.
- Timeout: fc_done held 0 -> err pulses exactly TIMEOUT_CYCLES cycles after WAIT_DONE entry; done never rises; result keeps its previous value; fc_state returns to 1.
- Start while busy: pulse start again at node 1, beat 10 -> no restart; read count stays 98; a single done pulse.
- Reset mid-operation: reset=0 during node 0, beat 20 -> all outputs return to reset values asynchronously. After release, a new start reproduces the nominal sequence exactly.
- Simultaneous events: fc_done=1 on the timeout-expiry cycle -> done=1, err=0, result captured. start on the done cycle is ignored; start one cycle later is accepted.
- Parameter variant OUTPUT_NODES=4, DRAIN_CYCLES=2 -> 196 reads, three 2-cycle zero gaps, node_idx steps 0..3, one done pulse.
